// File: rtl/csa_mult_seq.sv
`default_nettype none
// ============================================================================
// csa_mult_seq : sequential unsigned multiplier, two multiplier bits per cycle
//                through a 4:2 compressor row, then one carry-propagate add.
// Revision     : 1.0
// ============================================================================

module csa_compressor42 (
  input  logic x_i,
  input  logic y_i,
  input  logic z_i,
  input  logic w_i,
  input  logic tin_i,
  output logic s_o,
  output logic c_o,
  output logic tout_o
);
  logic w_s1;

  // tout depends only on x/y/z, so it never ripples along the row
  assign w_s1   = x_i ^ y_i ^ z_i;
  assign tout_o = (x_i & y_i) | (x_i & z_i) | (y_i & z_i);
  assign s_o    = w_s1 ^ w_i ^ tin_i;
  assign c_o    = (w_s1 & w_i) | (w_s1 & tin_i) | (w_i & tin_i);
endmodule

module csa_mult_seq #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               busy
);
  localparam int PW   = 2 * WIDTH;
  localparam int HALF = WIDTH / 2;
  localparam int IW   = $clog2(HALF) + 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COMPRESS = 2'd1,
    S_RESOLVE  = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    sum_q, sum_d;
  logic [PW-1:0]    carry_q, carry_d;
  logic [IW-1:0]    iter_q, iter_d;
  logic [PW-1:0]    prod_q, prod_d;

  logic [PW-1:0]    w_pp0, w_pp1;
  logic [PW-1:0]    w_s, w_c, w_tout, w_tin;
  logic             unused_top;

  assign w_pp0 = mplier_q[0] ? mcand_q : '0;
  assign w_pp1 = mplier_q[1] ? (mcand_q << 1) : '0;
  assign w_tin = {w_tout[PW-2:0], 1'b0};

  generate
    for (genvar i = 0; i < PW; i++) begin : g_row
      csa_compressor42 u_cmp (
        .x_i    (sum_q[i]),
        .y_i    (carry_q[i]),
        .z_i    (w_pp0[i]),
        .w_i    (w_pp1[i]),
        .tin_i  (w_tin[i]),
        .s_o    (w_s[i]),
        .c_o    (w_c[i]),
        .tout_o (w_tout[i])
      );
    end
  endgenerate

  // Top-bit carries fall off: the product always fits in PW bits
  assign unused_top = w_c[PW-1] ^ w_tout[PW-1];

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    iter_d   = iter_q;
    prod_d   = prod_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d  = {{WIDTH{1'b0}}, in_a};
          mplier_d = in_b;
          sum_d    = '0;
          carry_d  = '0;
          iter_d   = '0;
          state_d  = S_COMPRESS;
        end
      end
      S_COMPRESS: begin
        sum_d    = w_s;
        carry_d  = {w_c[PW-2:0], 1'b0};
        mcand_d  = mcand_q << 2;
        mplier_d = mplier_q >> 2;
        iter_d   = iter_q + IW'(1);
        if ((iter_d == IW'(HALF)) || (EARLY_EXIT && (mplier_d == '0))) begin
          state_d = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        prod_d  = sum_q + carry_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      sum_q    <= '0;
      carry_q  <= '0;
      iter_q   <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      iter_q   <= iter_d;
      prod_q   <= prod_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign busy        = (state_q == S_COMPRESS) || (state_q == S_RESOLVE);
  assign out_product = prod_q;
endmodule
`default_nettype wire

// File: tb/tb_csa_mult_seq.sv
`default_nettype none
// ============================================================================
// tb_csa_mult_seq : scoreboard bench, one instance per EARLY_EXIT setting.
// Revision        : 1.0
// ============================================================================
module tb_csa_mult_seq;
  logic        clk;
  logic        reset;
  logic        in_valid_s  [2];
  logic [31:0] in_a_s      [2];
  logic [31:0] in_b_s      [2];
  logic        out_ready_s [2];
  logic        in_ready_s  [2];
  logic        out_valid_s [2];
  logic        busy_s      [2];
  logic [63:0] prod_s      [2];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int          d;
    logic [63:0] prod;
    int          n;
    int          c0;
  } exp_t;
  exp_t sb[$];

  generate
    for (genvar k = 0; k < 2; k++) begin : g_dut
      csa_mult_seq #(.WIDTH(32), .EARLY_EXIT(k)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid_s[k]),
        .in_ready    (in_ready_s[k]),
        .in_a        (in_a_s[k]),
        .in_b        (in_b_s[k]),
        .out_valid   (out_valid_s[k]),
        .out_ready   (out_ready_s[k]),
        .out_product (prod_s[k]),
        .busy        (busy_s[k])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ref_iters(input int d, input logic [31:0] b);
    int bl;
    bl = 0;
    for (int i = 0; i < 32; i++) if (b[i]) bl = i + 1;
    if (d == 0) return 16;
    return (bl <= 2) ? 1 : (bl + 1) / 2;
  endfunction

  // Drives one operand pair and records the expected result at the accept edge
  task automatic issue(input int d, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   t;
    t = 0;
    while (!in_ready_s[d] && t < 100) begin
      @(posedge clk); #1; t++;
    end
    in_valid_s[d] = 1'b1;
    in_a_s[d]     = a;
    in_b_s[d]     = b;
    @(posedge clk); #1;
    in_valid_s[d] = 1'b0;
    e.d    = d;
    e.prod = {32'h0, a} * {32'h0, b};
    e.n    = ref_iters(d, b);
    e.c0   = cyc;
    sb.push_back(e);
  endtask

  // Waits for the result, checks latency/busy/product, applies stall, then handshakes
  task automatic drain_result(input int d, input int stall);
    exp_t e;
    int   t;
    int   nbusy;
    e = sb.pop_front();
    t = 0;
    nbusy = 0;
    forever begin
      @(negedge clk);
      if (out_valid_s[d] === 1'b1) break;
      if (busy_s[d] === 1'b1) nbusy++;
      t++;
      if (t > 100) break;
    end
    checks++;
    if (out_valid_s[d] !== 1'b1) begin
      errors++;
      $display("FAIL timeout dut%0d: out_valid=%b after %0d cycles, required 1", d, out_valid_s[d], t);
      return;
    end
    checks++;
    if (cyc - e.c0 !== e.n + 1) begin
      errors++;
      $display("FAIL latency dut%0d: got %0d required %0d", d, cyc - e.c0, e.n + 1);
    end
    checks++;
    if (nbusy !== e.n + 1) begin
      errors++;
      $display("FAIL busy_cycles dut%0d: got %0d required %0d", d, nbusy, e.n + 1);
    end
    checks++;
    if (prod_s[d] !== e.prod || busy_s[d] !== 1'b0 || in_ready_s[d] !== 1'b0) begin
      errors++;
      $display("FAIL product dut%0d: got %h busy=%b in_ready=%b required %h busy=0 in_ready=0",
               d, prod_s[d], busy_s[d], in_ready_s[d], e.prod);
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      checks++;
      if (out_valid_s[d] !== 1'b1 || prod_s[d] !== e.prod || in_ready_s[d] !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold dut%0d: valid=%b prod=%h in_ready=%b required 1/%h/0",
                 d, out_valid_s[d], prod_s[d], in_ready_s[d], e.prod);
      end
    end
    out_ready_s[d] = 1'b1;
    @(posedge clk); #1;
    out_ready_s[d] = 1'b0;
    checks++;
    if (out_valid_s[d] !== 1'b0 || prod_s[d] !== e.prod || in_ready_s[d] !== 1'b1) begin
      errors++;
      $display("FAIL release dut%0d: valid=%b prod=%h in_ready=%b required 0/%h/1",
               d, out_valid_s[d], prod_s[d], in_ready_s[d], e.prod);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (in_ready_s[d] !== 1'b1 || out_valid_s[d] !== 1'b0 || busy_s[d] !== 1'b0 || prod_s[d] !== 64'h0) begin
        errors++;
        $display("FAIL reset_state dut%0d: rdy=%b vld=%b busy=%b prod=%h required 1/0/0/0",
                 d, in_ready_s[d], out_valid_s[d], busy_s[d], prod_s[d]);
      end
    end
  endtask

  task automatic test_max_operands();
    issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain_result(0, 0);
    issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain_result(1, 0);
  endtask

  task automatic test_early_exit();
    issue(1, 32'd7, 32'd3);
    drain_result(1, 0);
    issue(1, 32'h0000_ABCD, 32'h0001_0000);
    drain_result(1, 0);
  endtask

  task automatic test_zero_identity();
    issue(1, 32'hCAFE_F00D, 32'h0);
    drain_result(1, 0);
    issue(1, 32'h1234_5678, 32'h1);
    drain_result(1, 0);
    issue(0, 32'h1234_5678, 32'h0);
    drain_result(0, 0);
  endtask

  task automatic test_backpressure();
    issue(1, 32'hDEAD_BEEF, 32'h10);
    fork
      begin
        @(posedge clk); #1;
        in_valid_s[1] = 1'b1;
        in_a_s[1]     = 32'h1111_1111;
        in_b_s[1]     = 32'hFFFF_0000;
        @(posedge clk); #1;
        in_valid_s[1] = 1'b0;
      end
      drain_result(1, 5);
    join
  endtask

  task automatic test_reset_mid_op();
    exp_t dropped;
    issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    dropped = sb.pop_back();
    checks++;
    if (in_ready_s[1] !== 1'b1 || out_valid_s[1] !== 1'b0 || busy_s[1] !== 1'b0 || prod_s[1] !== 64'h0) begin
      errors++;
      $display("FAIL mid_reset: rdy=%b vld=%b busy=%b prod=%h required 1/0/0/0 (dropped %h)",
               in_ready_s[1], out_valid_s[1], busy_s[1], prod_s[1], dropped.prod);
    end
    issue(1, 32'h8000_0000, 32'h2);
    drain_result(1, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    int          st;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 800; i++) begin
        a  = $urandom;
        b  = $urandom >> $urandom_range(0, 31);
        st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
        issue(d, a, b);
        drain_result(d, st);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid_s[d]  = 1'b0;
      in_a_s[d]      = '0;
      in_b_s[d]      = '0;
      out_ready_s[d] = 1'b0;
    end
    test_reset();
    test_max_operands();
    test_early_exit();
    test_zero_identity();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
